uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: BUSY_TIMEOUT, default 16; max cycles Tx_WR is held waiting for Tx_BUSY to rise.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 enable  in  1  high permits new grants; low blocks new grants only.
REQ-005 req0  in  1  requester 0 has a byte pending (level).
REQ-006 data0  in  8  requester 0 byte; stable while req0 high.
REQ-007 ack0  out  1  one-cycle pulse: data0 captured.
REQ-008 req1  in  1  requester 1 has a byte pending (level).
REQ-009 data1  in  8  requester 1 byte; stable while req1 high.
REQ-010 ack1  out  1  one-cycle pulse: data1 captured.
REQ-011 Tx_BUSY  in  1  transmitter busy flag.
REQ-012 Tx_WR  out  1  write strobe to transmitter.
REQ-013 Tx_DATA  out  8  byte to transmitter.
REQ-014 grant  out  2  one-hot owner of current transfer; 00 when idle.
REQ-015 sent_count  out  16  completed transfers.
REQ-016 timeout_err  out  1  sticky: a write got no Tx_BUSY response.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_BUSY, WAIT_DONE; all outputs registered.
REQ-018 IDLE -> WAIT_BUSY when enable=1, Tx_BUSY=0 and (req0|req1) at an edge; on that edge: Tx_DATA<=selected data, ackN<=1, grant<=onehot(N), Tx_WR<=1, timeout counter<=0.
REQ-019 Arbitration: single requester wins; both requesting -> requester not granted last time wins; last_grant updates at each grant.
REQ-020 ackN SHALL be high exactly one cycle per grant; requester may drop reqN or present the next byte from the cycle after ack.
REQ-021 IDLE with Tx_BUSY=1 (transmitter busy externally) or enable=0: no grant, no ack, Tx_WR=0.
REQ-022 WAIT_BUSY: Tx_WR held 1 and Tx_DATA held stable; counter increments each cycle.
REQ-023 WAIT_BUSY with Tx_BUSY=1 -> WAIT_DONE, Tx_WR<=0 on same edge.
REQ-024 WAIT_BUSY with counter = BUSY_TIMEOUT-1 and Tx_BUSY=0 -> IDLE, Tx_WR<=0, grant<=00, timeout_err<=1; byte dropped, no retry, sent_count unchanged.
REQ-025 WAIT_DONE with Tx_BUSY=0 -> IDLE, grant<=00, sent_count<=sent_count+1.
REQ-026 sent_count SHALL wrap 0xFFFF -> 0x0000.
REQ-027 Earliest next grant: edge after return to IDLE (minimum one idle cycle between transfers).
REQ-028 enable deasserted in WAIT_BUSY/WAIT_DONE: transfer completes normally; only next grant blocked.
REQ-029 Tx_DATA SHALL hold last transmitted byte while IDLE.
REQ-030 timeout_err cleared only by reset.

Reset
REQ-031 reset=1: state IDLE, Tx_WR=0, Tx_DATA=0x00, ack0=ack1=0, grant=00, sent_count=0, timeout_err=0, counter=0, last_grant=requester 1 (so requester 0 wins first contention).
REQ-032 reset asserted mid-transfer: Tx_WR drops asynchronously without waiting for clk; pending byte discarded, no ack reissued.
REQ-033 After reset release, first grant possible on the first rising edge with reset low.

Verification
REQ-034 req0=1 data0=0xAA, transmitter raises Tx_BUSY 3 cycles after Tx_WR, holds 20 cycles -> ack0 1-cycle pulse, Tx_DATA=0xAA, Tx_WR high 3 cycles, grant=01, sent_count=1.
REQ-035 req0 and req1 asserted together continuously, data0=0x11 data1=0x22, 4 transfers -> Tx_DATA order 0x11,0x22,0x11,0x22; acks alternate; sent_count=4.
REQ-036 Transmitter never raises Tx_BUSY, BUSY_TIMEOUT=16 -> Tx_WR high exactly 16 cycles, timeout_err=1, grant=00, sent_count=0; next request still serviced.
REQ-037 Tx_BUSY held high externally with req1=1 -> no ack1 until Tx_BUSY low; then grant within 1 cycle.
REQ-038 reset pulsed while in WAIT_DONE -> Tx_WR=0, grant=00, sent_count=0 immediately; subsequent req0 granted normally.
REQ-039 Preload 0xFFFF completions (force or 65536 transfers) -> sent_count wraps to 0x0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding a single UART transmitter: fair round-robin grant,
// write strobe held until the transmitter reports busy, completion counting and timeout flag.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        req0,
    input  logic [7:0]  data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        ack1,
    input  logic        Tx_BUSY,
    output logic        Tx_WR,
    output logic [7:0]  Tx_DATA,
    output logic [1:0]  grant,
    output logic [15:0] sent_count,
    output logic        timeout_err
);

    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic             last_grant;
    logic             pick1;

    // Requester 1 wins when alone, or on contention when requester 0 was served last.
    always_comb begin
        pick1 = req1 && (!req0 || !last_grant);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy_cnt    <= '0;
            last_grant  <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= 8'h00;
            grant       <= 2'b00;
            sent_count  <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !Tx_BUSY && (req0 || req1)) begin
                        state      <= WAIT_BUSY;
                        busy_cnt   <= '0;
                        Tx_WR      <= 1'b1;
                        last_grant <= pick1;
                        Tx_DATA    <= pick1 ? data1 : data0;
                        ack0       <= !pick1;
                        ack1       <= pick1;
                        grant      <= pick1 ? 2'b10 : 2'b01;
                    end
                end
                WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state <= WAIT_DONE;
                        Tx_WR <= 1'b0;
                    end else if (busy_cnt == CNT_LAST) begin
                        // Transmitter never answered: the byte is dropped, not retried.
                        state       <= IDLE;
                        Tx_WR       <= 1'b0;
                        grant       <= 2'b00;
                        timeout_err <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        sent_count <= sent_count + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Tx_WR <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule
